// File: rtl/io_pkg.sv
// Shared constants for the board input-conditioning block:
// LSU address map of the input peripherals and the word layout.
package io_pkg;

    localparam logic [31:0] IO_SW_ADDR  = 32'h7800;
    localparam logic [31:0] IO_BTN_ADDR = 32'h7810;
    localparam int          BTN_EVT_LSB = 16;
    localparam int          IO_WORD_W   = 32;

endpackage

// File: rtl/io_debounce_bit.sv
// One conditioned input bit: 2-flop synchronizer, stability counter
// and accepted level. take flags the edge on which level will flip.
module io_debounce_bit #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic take
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic       meta;
    logic       s;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            s    <= 1'b0;
        end else begin
            meta <= raw;
            s    <= meta;
        end
    end

    // Combinational view of the accept decision, consumed by the edge logic.
    always_comb begin
        take = (s != level) && (cnt == CNT_LAST);
    end

    // Accept a new level only after it has been stable long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s == level) begin
            cnt <= '0;
        end else if (take) begin
            level <= s;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/io_input_cond.sv
// Debounces switches and keys, tracks sticky key-press events and
// packs everything into the 32-bit words read by the LSU.
module io_input_cond
    import io_pkg::*;
#(
    parameter int N_SW       = 18,
    parameter int N_BTN      = 4,
    parameter int DEB_CYCLES = 500000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_SW-1:0]      i_sw_raw,
    input  logic [N_BTN-1:0]     i_btn_n_raw,
    input  logic                 i_evt_clr,
    input  logic [N_BTN-1:0]     i_evt_clr_mask,
    output logic [IO_WORD_W-1:0] o_io_sw,
    output logic [IO_WORD_W-1:0] o_io_btn,
    output logic [N_BTN-1:0]     o_btn_press,
    output logic                 o_evt_pend
);

    logic [N_SW-1:0]  sw_q;
    logic [N_SW-1:0]  sw_take;
    logic [N_BTN-1:0] btn_q;
    logic [N_BTN-1:0] btn_take;
    logic [N_BTN-1:0] press_nxt;
    logic [N_BTN-1:0] flag;
    logic [N_BTN-1:0] flag_nxt;
    logic [N_BTN-1:0] clr_sel;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        io_debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (i_clk),
            .rst_n (i_rst),
            .raw   (i_sw_raw[i]),
            .level (sw_q[i]),
            .take  (sw_take[i])
        );
    end

    // Keys are inverted before synchronizing so idle reset state means released.
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        io_debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (i_clk),
            .rst_n (i_rst),
            .raw   (~i_btn_n_raw[i]),
            .level (btn_q[i]),
            .take  (btn_take[i])
        );
    end

    // Press is detected one edge early so pulse and flag align with level.
    always_comb begin
        press_nxt = btn_take & ~btn_q;
        clr_sel   = i_evt_clr ? i_evt_clr_mask : '0;
        flag_nxt  = (flag & ~clr_sel) | press_nxt;
    end

    // Register press pulses, sticky flags and the pending summary together.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_btn_press <= '0;
            flag        <= '0;
            o_evt_pend  <= 1'b0;
        end else begin
            o_btn_press <= press_nxt;
            flag        <= flag_nxt;
            o_evt_pend  <= |flag_nxt;
        end
    end

    // Pack registered state into the LSU-visible words.
    always_comb begin
        o_io_sw = '0;
        o_io_sw[N_SW-1:0] = sw_q;
        o_io_btn = '0;
        o_io_btn[N_BTN-1:0] = btn_q;
        o_io_btn[BTN_EVT_LSB +: N_BTN] = flag;
    end

    logic unused_sw_take;
    assign unused_sw_take = ^sw_take;

endmodule
